fp_norm_round_pipe: RTL and testbench

- Stage that sits directly downstream of the 32-bit leading-zero counter in the FP multiplier datapath.
- Takes an unnormalised 32-bit significand together with its LZC count and valid bit. Left-normalises the significand, adjusts the exponent, and rounds to nearest-even at 24 bits.
- Packs the result as IEEE-754 single with status flags.
- Two-stage pipeline with valid/ready handshake. Throughput is one result per cycle.

---
 rtl/fp_mul_pkg.sv | 15 +
 rtl/fp_round_pack.sv | 61 ++++++
 rtl/fp_norm_round_pipe.sv | 81 ++++++++
 tb/tb_fp_norm_round_pipe.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_mul_pkg.sv
// Shared constants for the FP multiplier datapath: IEEE-754 single field widths,
// bias, the Inf exponent code and status flag bit positions.
package fp_mul_pkg;

    localparam int EXP_BITS  = 8;
    localparam int FRAC_BITS = 23;
    localparam int BIAS      = 127;
    localparam int EXP_MAX   = 255;

    localparam int FLG_OVF  = 3;
    localparam int FLG_UNF  = 2;
    localparam int FLG_INX  = 1;
    localparam int FLG_ZERO = 0;

endpackage

// File: rtl/fp_round_pack.sv
// Round-to-nearest-even at 24 bits and pack a normalised significand as IEEE single.
// Latency: combinational.
// Backpressure: none; the caller registers the outputs.
module fp_round_pack #(
    parameter int EXP_W   = 10,
    parameter int EXP_MAX = fp_mul_pkg::EXP_MAX
) (
    input  logic [31:0]              norm,
    input  logic signed [EXP_W:0]    exp_adj,
    input  logic                     sign,
    input  logic                     nz,
    output logic [31:0]              result,
    output logic [3:0]               flags
);
    import fp_mul_pkg::*;

    localparam logic signed [EXP_W+1:0] EXP_MAX_S = (EXP_W+2)'(EXP_MAX);

    logic [23:0]              mant;
    logic                     guard;
    logic                     sticky;
    logic                     round_up;
    logic [24:0]              m25;
    logic [FRAC_BITS-1:0]     frac;
    logic signed [EXP_W+1:0]  exp_f;
    logic                     unused_hidden;

    // m25[23] is the hidden bit; only the carry into bit 24 matters.
    assign unused_hidden = m25[23];

    always_comb begin
        mant     = norm[31:8];
        guard    = norm[7];
        sticky   = |norm[6:0];
        round_up = guard & (sticky | norm[8]);
        m25      = {1'b0, mant} + {24'b0, round_up};
        exp_f    = {exp_adj[EXP_W], exp_adj} + {{(EXP_W+1){1'b0}}, m25[24]};
        frac     = m25[24] ? '0 : m25[22:0];

        result = '0;
        flags  = '0;
        if (!nz) begin
            result          = {sign, 31'b0};
            flags[FLG_ZERO] = 1'b1;
        end else if (exp_f >= EXP_MAX_S) begin
            result         = {sign, 8'hFF, 23'b0};
            flags[FLG_OVF] = 1'b1;
            flags[FLG_INX] = 1'b1;
        end else if (exp_f[EXP_W+1] || exp_f == '0) begin
            // No subnormals: anything at or below exponent zero flushes to signed zero.
            result          = {sign, 31'b0};
            flags[FLG_UNF]  = 1'b1;
            flags[FLG_INX]  = 1'b1;
            flags[FLG_ZERO] = 1'b1;
        end else begin
            result         = {sign, exp_f[EXP_BITS-1:0], frac};
            flags[FLG_INX] = guard | sticky;
        end
    end

endmodule

// File: rtl/fp_norm_round_pipe.sv
// Normalise (shift by LZC count), round to nearest-even and pack as IEEE single.
// Latency: 2 cycles, one result per cycle.
// Backpressure: valid/ready; in_ready = !s1_valid | s2_take, outputs held while stalled.
module fp_norm_round_pipe #(
    parameter int EXP_W   = 10,
    parameter int EXP_MAX = fp_mul_pkg::EXP_MAX
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_sign,
    input  logic [EXP_W-1:0] in_exp,
    input  logic [31:0]      in_sig,
    input  logic [4:0]       in_lz,
    input  logic             in_nz,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_result,
    output logic [3:0]       out_flags
);
    import fp_mul_pkg::*;

    logic                    s1_valid;
    logic                    s1_sign;
    logic                    s1_nz;
    logic [31:0]             s1_norm;
    logic signed [EXP_W:0]   s1_exp_adj;
    logic                    s2_take;
    logic [31:0]             rp_result;
    logic [3:0]              rp_flags;

    assign s2_take  = !out_valid || out_ready;
    assign in_ready = !s1_valid || s2_take;

    // Stage 1: normalising shift and exponent adjust; in_lz is trusted as-is.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid   <= 1'b0;
            s1_sign    <= 1'b0;
            s1_nz      <= 1'b0;
            s1_norm    <= '0;
            s1_exp_adj <= '0;
        end else if (in_ready) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_sign    <= in_sign;
                s1_nz      <= in_nz;
                s1_norm    <= in_sig << in_lz;
                s1_exp_adj <= {in_exp[EXP_W-1], in_exp} - {{(EXP_W-4){1'b0}}, in_lz};
            end
        end
    end

    fp_round_pack #(
        .EXP_W   (EXP_W),
        .EXP_MAX (EXP_MAX)
    ) u_round_pack (
        .norm    (s1_norm),
        .exp_adj (s1_exp_adj),
        .sign    (s1_sign),
        .nz      (s1_nz),
        .result  (rp_result),
        .flags   (rp_flags)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_result <= '0;
            out_flags  <= '0;
        end else if (s2_take) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_result <= rp_result;
                out_flags  <= rp_flags;
            end
        end
    end

endmodule

// File: tb/tb_fp_norm_round_pipe.sv
// Scoreboard bench for fp_norm_round_pipe: directed vectors, backpressure, reset flush
// and randomized beats checked against an arithmetic reference model.
module tb_fp_norm_round_pipe;
    localparam int EXP_W = 10;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic             in_sign = 1'b0;
    logic [EXP_W-1:0] in_exp = '0;
    logic [31:0]      in_sig = '0;
    logic [4:0]       in_lz = '0;
    logic             in_nz = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [31:0]      out_result;
    logic [3:0]       out_flags;

    always #5 clk = ~clk;

    fp_norm_round_pipe #(.EXP_W(EXP_W), .EXP_MAX(255)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_sign    (in_sign),
        .in_exp     (in_exp),
        .in_sig     (in_sig),
        .in_lz      (in_lz),
        .in_nz      (in_nz),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_flags  (out_flags)
    );

    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc = 0;
    int          last_issue = 0;
    logic [35:0] exp_q[$];
    logic        rand_rdy = 1'b0;
    logic        rdy_force = 1'b1;
    logic        hold_vld = 1'b0;
    logic [35:0] hold_dat = '0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        out_ready = rand_rdy ? ($urandom_range(0, 3) != 0) : rdy_force;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference: value = sig * 2^(exp-158); round the 32-bit normalised value to 24 bits.
    function automatic logic [35:0] model(input logic s, input int e, input logic [31:0] sig,
                                          input int lz, input logic nz);
        logic [31:0] n;
        int          m;
        int          r;
        int          ef;
        logic        inx;
        if (!nz) return {s, 31'b0, 4'b0001};
        n   = sig << lz;
        m   = int'(n >> 8);
        r   = int'(n & 32'hFF);
        inx = (r != 0);
        if (r > 128 || (r == 128 && (m % 2) == 1)) m++;
        ef = e - lz;
        if (m == (1 << 24)) begin
            m = 1 << 23;
            ef++;
        end
        if (ef >= 255) return {s, 8'hFF, 23'b0, 4'b1010};
        if (ef <= 0) return {s, 31'b0, 4'b0111};
        return {s, ef[7:0], m[22:0], 1'b0, 1'b0, inx, 1'b0};
    endfunction

    // Scoreboard monitor: hold stability while stalled, in-order compare on transfer.
    always @(negedge clk) begin
        if (rst) begin
            hold_vld = 1'b0;
        end else begin
            if (hold_vld)
                check("hold_stable", 64'({out_valid, out_result, out_flags}), 64'({1'b1, hold_dat}));
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_output: got %h expected no output", {out_result, out_flags});
                end else begin
                    check("result", 64'({out_result, out_flags}), 64'(exp_q.pop_front()));
                end
            end
            hold_vld = out_valid && !out_ready;
            hold_dat = {out_result, out_flags};
        end
    end

    // Called at posedge+1; returns at posedge+1 right after the transfer edge.
    task automatic send(input logic s, input logic [EXP_W-1:0] e, input logic [31:0] sig,
                        input logic [4:0] lz, input logic nz, input logic [35:0] expv);
        in_valid = 1'b1;
        in_sign  = s;
        in_exp   = e;
        in_sig   = sig;
        in_lz    = lz;
        in_nz    = nz;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (in_ready) begin
                exp_q.push_back(expv);
                last_issue = cyc;
                @(posedge clk);
                #1;
                in_valid = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
        end
        n_cmp++;
        n_bad++;
        $display("FAIL send_timeout: in_ready stayed 0 expected 1 within 300 cycles");
        in_valid = 1'b0;
    endtask

    task automatic send_rand(input logic [35:0] dummy_unused);
        logic [4:0]  lz;
        logic [31:0] sig;
        logic        s;
        logic        nz;
        int          ei;
        lz  = 5'($urandom_range(0, 31));
        sig = ($urandom() | 32'h8000_0000) >> lz;
        s   = 1'($urandom_range(0, 1));
        nz  = ($urandom_range(0, 15) != 0);
        if (!nz) sig = '0;
        if ($urandom_range(0, 3) == 0) ei = int'($urandom_range(0, 1023)) - 512;
        else ei = int'($urandom_range(0, 320)) - 20;
        send(s, 10'(ei), sig, lz, nz, model(s, ei, sig, int'(lz), nz));
        if (dummy_unused != '0) @(posedge clk);
    endtask

    task automatic drain();
        for (int k = 0; k < 1000 && exp_q.size() != 0; k++) @(posedge clk);
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain_timeout: %0d results outstanding expected 0", exp_q.size());
            exp_q.delete();
        end
        #1;
    endtask

    typedef struct {
        logic             s;
        logic [EXP_W-1:0] e;
        logic [31:0]      sig;
        logic [4:0]       lz;
        logic             nz;
        logic [35:0]      ex;
    } vec_t;

    vec_t dir[6];
    logic seen;

    initial begin
        dir[0] = '{1'b0, 10'd158, 32'h0000_0001, 5'd31, 1'b1, {32'h3F80_0000, 4'b0000}};
        dir[1] = '{1'b0, 10'd127, 32'hFFFF_FF80, 5'd0,  1'b1, {32'h4000_0000, 4'b0010}};
        dir[2] = '{1'b0, 10'd127, 32'h8000_0080, 5'd0,  1'b1, {32'h3F80_0000, 4'b0010}};
        dir[3] = '{1'b1, 10'd254, 32'hFFFF_FFFF, 5'd0,  1'b1, {32'hFF80_0000, 4'b1010}};
        dir[4] = '{1'b0, 10'd10,  32'h0001_0000, 5'd15, 1'b1, {32'h0000_0000, 4'b0111}};
        dir[5] = '{1'b1, 10'd50,  32'h0000_0000, 5'd0,  1'b0, {32'h8000_0000, 4'b0001}};

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_out_result", 64'(out_result), 64'd0);
        check("reset_out_flags", 64'(out_flags), 64'd0);
        check("reset_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;

        // Directed vectors with latency check on the first.
        send(dir[0].s, dir[0].e, dir[0].sig, dir[0].lz, dir[0].nz, dir[0].ex);
        seen = 1'b0;
        for (int k = 0; k < 10 && !seen; k++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
            else @(posedge clk);
        end
        check("latency", 64'(cyc - last_issue), 64'd2);
        @(posedge clk);
        #1;
        for (int i = 1; i < 6; i++)
            send(dir[i].s, dir[i].e, dir[i].sig, dir[i].lz, dir[i].nz, dir[i].ex);
        drain();

        // Backpressure: two beats fill the pipe, third waits until the consumer resumes.
        rdy_force = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        send_rand('0);
        send_rand('0);
        fork
            send_rand('0);
            begin
                @(negedge clk);
                check("bp_in_ready", 64'(in_ready), 64'd0);
                repeat (4) @(posedge clk);
                #1;
                rdy_force = 1'b1;
            end
        join
        drain();

        // Reset with both stages full: nothing in flight may surface.
        rdy_force = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        send_rand('0);
        send_rand('0);
        @(negedge clk);
        check("full_out_valid", 64'(out_valid), 64'd1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        exp_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        rdy_force = 1'b1;
        @(negedge clk);
        check("flush_out_valid", 64'(out_valid), 64'd0);
        check("flush_out_result", 64'(out_result), 64'd0);
        check("flush_out_flags", 64'(out_flags), 64'd0);
        check("flush_in_ready", 64'(in_ready), 64'd1);
        repeat (8) @(posedge clk);
        #1;

        // Randomized traffic with random consumer stalls.
        rand_rdy = 1'b1;
        for (int i = 0; i < 400; i++) begin
            send_rand('0);
            if ($urandom_range(0, 4) == 0) begin
                @(posedge clk);
                #1;
            end
        end
        rand_rdy = 1'b0;
        drain();
        repeat (4) @(posedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached before completion");
        $fatal(1, "watchdog");
    end

endmodule
